// File: rtl/processor_pkg.sv
// processor_pkg: constants and types shared by the processor front end.
package processor_pkg;
    localparam int INSTR_WIDTH = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: shallow FIFO of {addr, word} with the head always at index 0; flush beats push.
module fetch_buffer #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] entries [DEPTH];
    logic [WIDTH-1:0] shifted [DEPTH];
    logic [CW-1:0] count;
    int wr_idx;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) shifted[i] = entries[i];
        for (int i = 0; i < DEPTH - 1; i++) shifted[i] = entries[i + 1];
        wr_idx = int'(count) - (pop ? 1 : 0);
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (flush) count <= '0;
        else count <= count + CW'(push) - CW'(pop);
    // Payload needs no reset: count alone decides what is visible.
    always_ff @(posedge clock)
        for (int i = 0; i < DEPTH; i++)
            if (push && wr_idx == i) entries[i] <= din;
            else if (pop) entries[i] <= shifted[i];
    assign head = entries[0];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, runs the memory read handshake, redirects and squashes on branches.
// Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer; otherwise a single entry is used.
module instruction_fetch_unit
    import processor_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memReadEn,
    input  logic                  memReady,
    input  logic [15:0]           memData,
    output logic [15:0]           instruction,
    output logic                  instrValid,
    input  logic                  decodeReady,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic [ADDR_WIDTH-1:0] fetchPC
);
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;
    fetch_state_t state;
    logic [ADDR_WIDTH-1:0] addr, target;
    logic squash, full, empty, push, pop, space;
    logic [EW-1:0] head;
    assign pop = !empty && decodeReady;
    assign space = !full || pop;
    assign push = state == WAIT && memReady && !squash && !branchTaken;
    assign memAddr = addr;
    assign memReadEn = state == WAIT || (state == REQ && space);
    assign instrValid = !empty;
    assign instruction = empty ? NOP_INSTR : head[INSTR_WIDTH-1:0];
    assign fetchPC = empty ? addr : head[EW-1:INSTR_WIDTH];
    fetch_buffer #(.DEPTH(DEPTH), .WIDTH(EW)) u_buf (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(branchTaken),
        .din({addr, memData}),
        .head(head),
        .full(full),
        .empty(empty)
    );
    // A request already on the bus is never withdrawn: a branch then parks its target until the read drains.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            addr <= RESET_PC;
            target <= RESET_PC;
            squash <= 1'b0;
        end else
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (branchTaken) addr <= branchTarget;
                end
                REQ:
                    if (space) begin
                        state <= WAIT;
                        if (branchTaken) begin
                            squash <= 1'b1;
                            target <= branchTarget;
                        end
                    end else if (branchTaken) addr <= branchTarget;
                WAIT:
                    if (memReady) begin
                        state <= REQ;
                        squash <= 1'b0;
                        addr <= branchTaken ? branchTarget : squash ? target : addr + 1'b1;
                    end else if (branchTaken) begin
                        squash <= 1'b1;
                        target <= branchTarget;
                    end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, stall, branch/squash, wrap and async reset.
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [15:0] memAddr;
    logic memReadEn;
    logic memReady = 1'b0;
    logic [15:0] memData = 16'hDEAD;
    logic [15:0] instruction;
    logic instrValid;
    logic decodeReady = 1'b0;
    logic branchTaken = 1'b0;
    logic [15:0] branchTarget = 16'h0000;
    logic [15:0] fetchPC;
    int checks = 0;
    int errors = 0;
    int lat = 0;
    int cnt = 0;

    instruction_fetch_unit dut (
        .clock(clock),
        .reset(reset),
        .memAddr(memAddr),
        .memReadEn(memReadEn),
        .memReady(memReady),
        .memData(memData),
        .instruction(instruction),
        .instrValid(instrValid),
        .decodeReady(decodeReady),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .fetchPC(fetchPC)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h5A31 : a ^ 16'hC3A5;
    endfunction

    // Memory answers after lat extra WAIT cycles; evaluated after the bench has driven its inputs.
    initial forever begin
        @(negedge clock);
        #2;
        if (memReady || !memReadEn) cnt = memReadEn ? 1 : 0;
        else cnt++;
        memReady = memReadEn && cnt == lat + 2;
        memData = memReady ? mem_word(memAddr) : 16'hDEAD;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        branchTaken = 1'b0;
        decodeReady = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (memReadEn !== 1'b0) begin errors++; $display("FAIL rst_readen: got %b want 0", memReadEn); end
        checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", memAddr); end
        checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL rst_instr: got %h want 0000", instruction); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instrValid); end
        checks++; if (fetchPC !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", fetchPC); end
    endtask

    task automatic test_first_fetch();
        lat = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL ff_valid1: got %b want 0", instrValid); end
        checks++; if (memReadEn !== 1'b1) begin errors++; $display("FAIL ff_readen: got %b want 1", memReadEn); end
        checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL ff_addr0: got %h want 0000", memAddr); end
        @(negedge clock);
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL ff_valid2: got %b want 0", instrValid); end
        @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL ff_valid3: got %b want 1", instrValid); end
        checks++; if (instruction !== 16'h5A31) begin errors++; $display("FAIL ff_instr: got %h want 5a31", instruction); end
        checks++; if (fetchPC !== 16'h0000) begin errors++; $display("FAIL ff_pc: got %h want 0000", fetchPC); end
        checks++; if (memAddr !== 16'h0001) begin errors++; $display("FAIL ff_addr1: got %h want 0001", memAddr); end
    endtask

    task automatic test_stall();
        logic [15:0] got [3];
        logic [15:0] want [3];
        int n = 0;
        want[0] = 16'h5A31;
        want[1] = 16'hC3A4;
        want[2] = 16'hC3A7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instrValid); end
            checks++; if (instruction !== 16'h5A31) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 5a31", i, instruction); end
        end
        decodeReady = 1'b1;
        for (int i = 0; i < 20 && n < 3; i++) begin
            if (instrValid) begin
                got[n] = instruction;
                n++;
            end
            @(negedge clock);
        end
        decodeReady = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL stall_timeout: got %0d words want 3", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL stall_seq[%0d]: got %h want %h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_branch_wait();
        lat = 3;
        do_reset();
        repeat (2) @(negedge clock);
        checks++; if (memReadEn !== 1'b1) begin errors++; $display("FAIL bw_pre: got %b want 1", memReadEn); end
        branchTaken = 1'b1;
        branchTarget = 16'h0040;
        @(negedge clock);
        branchTaken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (memAddr !== 16'h0000 || memReadEn !== 1'b1) begin errors++; $display("FAIL bw_hold[%0d]: got addr %h en %b want 0000 1", i, memAddr, memReadEn); end
            checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL bw_valid[%0d]: got %b want 0", i, instrValid); end
            @(negedge clock);
        end
        lat = 0;
        checks++; if (memAddr !== 16'h0040) begin errors++; $display("FAIL bw_addr: got %h want 0040", memAddr); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL bw_valid3: got %b want 0", instrValid); end
        @(negedge clock);
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL bw_valid4: got %b want 0", instrValid); end
        @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL bw_valid5: got %b want 1", instrValid); end
        checks++; if (instruction !== 16'hC3E5) begin errors++; $display("FAIL bw_instr: got %h want c3e5", instruction); end
        checks++; if (fetchPC !== 16'h0040) begin errors++; $display("FAIL bw_pc: got %h want 0040", fetchPC); end
    endtask

    task automatic test_branch_same_cycle();
        lat = 0;
        do_reset();
        repeat (2) @(negedge clock);
        checks++; if (memReadEn !== 1'b1) begin errors++; $display("FAIL bs_pre: got %b want 1", memReadEn); end
        branchTaken = 1'b1;
        branchTarget = 16'h0100;
        @(negedge clock);
        branchTaken = 1'b0;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL bs_valid: got %b want 0", instrValid); end
        checks++; if (memAddr !== 16'h0100) begin errors++; $display("FAIL bs_addr: got %h want 0100", memAddr); end
        checks++; if (memReadEn !== 1'b1) begin errors++; $display("FAIL bs_readen: got %b want 1", memReadEn); end
        repeat (2) @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL bs_valid2: got %b want 1", instrValid); end
        checks++; if (instruction !== 16'hC2A5) begin errors++; $display("FAIL bs_instr: got %h want c2a5", instruction); end
        checks++; if (fetchPC !== 16'h0100) begin errors++; $display("FAIL bs_pc: got %h want 0100", fetchPC); end
    endtask

    task automatic test_flush();
        int i = 0;
        lat = 0;
        do_reset();
        repeat (3) @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL fl_pre: got %b want 1", instrValid); end
        branchTaken = 1'b1;
        branchTarget = 16'h0200;
        @(negedge clock);
        branchTaken = 1'b0;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", instrValid); end
        checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL fl_instr: got %h want 0000", instruction); end
        while (!instrValid && i < 20) begin
            @(negedge clock);
            i++;
        end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL fl_timeout: got %b want 1", instrValid); end
        checks++; if (instruction !== 16'hC1A5) begin errors++; $display("FAIL fl_new: got %h want c1a5", instruction); end
        checks++; if (fetchPC !== 16'h0200) begin errors++; $display("FAIL fl_pc: got %h want 0200", fetchPC); end
    endtask

    task automatic test_wrap();
        lat = 0;
        do_reset();
        repeat (2) @(negedge clock);
        branchTaken = 1'b1;
        branchTarget = 16'hFFFF;
        @(negedge clock);
        branchTaken = 1'b0;
        checks++; if (memAddr !== 16'hFFFF) begin errors++; $display("FAIL wr_addr: got %h want ffff", memAddr); end
        repeat (2) @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b want 1", instrValid); end
        checks++; if (instruction !== 16'h3C5A) begin errors++; $display("FAIL wr_instr: got %h want 3c5a", instruction); end
        checks++; if (fetchPC !== 16'hFFFF) begin errors++; $display("FAIL wr_pc: got %h want ffff", fetchPC); end
        checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL wr_next: got %h want 0000", memAddr); end
    endtask

    task automatic test_reset_mid();
        lat = 5;
        do_reset();
        repeat (2) @(negedge clock);
        checks++; if (memReadEn !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b want 1", memReadEn); end
        #3 reset = 1'b0;
        #1;
        checks++; if (memReadEn !== 1'b0) begin errors++; $display("FAIL rm_readen: got %b want 0", memReadEn); end
        checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL rm_addr: got %h want 0000", memAddr); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", instrValid); end
        lat = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL rm_pre2: got %b want 1", instrValid); end
        #3 reset = 1'b0;
        #1;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rm_valid2: got %b want 0", instrValid); end
        checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL rm_instr: got %h want 0000", instruction); end
        checks++; if (fetchPC !== 16'h0000) begin errors++; $display("FAIL rm_pc: got %h want 0000", fetchPC); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_wait();
        test_branch_same_cycle();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential front end that produces the 16-bit instruction stream consumed by the control decoder. It owns the program counter and issues word reads to instruction memory over a ready-based handshake. It buffers returned words and presents them to the decoder with a valid/ready handshake. It redirects on taken branches, squashing any in-flight or buffered wrong-path words.

## Interface
- ADDR_WIDTH, 16: program counter and memory address width; word-addressed.
- RESET_PC, 16'h0000: address of the first fetch after reset.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- memAddr  out  ADDR_WIDTH  read address; stable while memReadEn is high.
- memReadEn  out  1  read request; held until memReady is sampled high.
- memReady  in  1  memory has returned memData this cycle.
- memData  in  16  instruction word; valid only when memReady is high.
- instruction  out  16  instruction to the decoder; driven to NOP (16'h0000) when not valid.
- instrValid  out  1  instruction holds a correct-path word.
- decodeReady  in  1  decoder accepts instruction this cycle.
- branchTaken  in  1  redirect request; single-cycle pulse.
- branchTarget  in  ADDR_WIDTH  redirect address; sampled when branchTaken is high.
- fetchPC  out  ADDR_WIDTH  address of the word currently on instruction; for link/debug.

## Operation
- Reset values: memAddr=RESET_PC, memReadEn=0, instruction=16'h0000, instrValid=0, fetchPC=RESET_PC, buffer empty, squash=0, state=IDLE.
- FSM states:
  - IDLE: the first cycle after reset deasserts; next state is REQ.
  - REQ: drives memReadEn=1 and memAddr=PC.
    - Moves to WAIT only when buffer space exists. Space is counted as the free entries minus any outstanding request.
    - If there is no space, the FSM stays in REQ with memReadEn=0.
  - WAIT: holds memReadEn and memAddr stable until memReady.
    - On memReady with squash=0: writes memData and its address into the buffer, sets PC=PC+1, returns to REQ.
- PC arithmetic is modulo 2^ADDR_WIDTH; 16'hFFFF+1 wraps to 16'h0000 with no flag.
- Transfers to the decoder:
  - The buffer head drives instruction/fetchPC; instrValid = buffer not empty.
  - A pop occurs when instrValid && decodeReady.
  - instruction and instrValid hold unchanged while instrValid=1 and decodeReady=0.
- Branch handling (branchTaken=1): highest priority after reset.
  - Buffer is flushed in the same edge, so instrValid=0 the next cycle. Any pop in that cycle is still honoured.
  - PC = branchTarget.
  - If the FSM is in WAIT, squash is set. The outstanding read completes normally and its memData is discarded when memReady arrives. squash then clears and the FSM goes to REQ with PC=target.
  - memReady in the same cycle as branchTaken: the returned data is discarded.
- Branch during a squash: PC is overwritten with the newest target. Only one discard is needed.
- memReadEn is never withdrawn while a request is outstanding. Requests are never aborted.
- reset asserted mid-fetch: all state clears asynchronously. The memory must tolerate an abandoned request.

## Timing
- Zero-wait memory (memReady in the first WAIT cycle): the returned word is visible on instruction the cycle after memReady.
- Steady-state throughput is one word per two cycles in single-entry mode (REQ+WAIT). Prefetch mode overlaps REQ with a held decoder.
- First instruction after reset release: the earliest instrValid is 3 cycles after release with zero-wait memory (IDLE, REQ, WAIT).
- Branch penalty: instrValid is low for at least 2 cycles after branchTaken with zero-wait memory, plus any remaining latency of a squashed read.

## Configuration
- FETCH_PREFETCH_EN:
  - Defined: the buffer is a 2-entry FIFO, and the unit fetches ahead while the decoder stalls.
  - Undefined: the buffer is 1 entry, and the next request is issued only when the buffer is empty or being popped that cycle.
- Branch, squash and handshake rules are identical in both modes.

## Structure
- Shared package processor_pkg holds:
  - NOP_INSTR = 16'h0000 (R-type opcode, NOP ExOp).
  - The fetch FSM state enum (IDLE, REQ, WAIT).
  - The default RESET_PC.
- Sub-module fetch_buffer: a depth-parameterised (1 or 2) FIFO of {addr, word} with push, pop, flush, full and empty. Flush has priority over push.

## Test plan
- Reset release, zero-wait memory returning 16'h5A31 at 0: instrValid rises on the 3rd cycle with instruction=16'h5A31, fetchPC=0, and memAddr then advances to 1.
- Decoder stall (decodeReady=0 for 5 cycles) with a valid word present: instruction and instrValid are unchanged throughout, and no word is lost or duplicated after release.
- branchTaken with target 16'h0040 while WAIT is outstanding and memReady comes 3 cycles later: the returned word is discarded, the next memAddr is 16'h0040, and no wrong-path instrValid appears.
- branchTaken in the same cycle as memReady: the data is discarded, the buffer is flushed, and fetch resumes at the target.
- PC at 16'hFFFF: after that word is fetched, the next memAddr is 16'h0000.
- reset asserted while WAIT is outstanding: memReadEn=0, instrValid=0 and instruction=16'h0000 immediately, with no clock edge needed.
